// File: rtl/ru_pkg.sv
// Shared types and constants for the register_unit integer register file.
// Optional write-to-read forwarding is selected with the RU_WRITE_BYPASS_EN macro.
package ru_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd0;
  localparam reg_idx_t SP_REG   = 5'd2;

endpackage

// File: rtl/ru_read_port.sv
// One combinational read port of the register file, including the x0 rule.
// When RU_WRITE_BYPASS_EN is defined, an in-flight write to the addressed register is forwarded.
module ru_read_port
  import ru_pkg::*;
#(
  parameter int XLEN  = ru_pkg::XLEN,
  parameter int NREGS = ru_pkg::NREGS
) (
  input  logic [XLEN-1:0] i_regs [NREGS],
  input  reg_idx_t        i_addr,
`ifdef RU_WRITE_BYPASS_EN
  input  logic            i_rst,
  input  logic            i_wrEn,
  input  reg_idx_t        i_wrAddr,
  input  logic [XLEN-1:0] i_wrData,
`endif
  output logic [XLEN-1:0] o_data
);

  // The x0 override is applied last so it beats a forwarded write.
  always_comb begin
    o_data = i_regs[i_addr];
`ifdef RU_WRITE_BYPASS_EN
    if (!i_rst && i_wrEn && (i_wrAddr != ZERO_REG) && (i_wrAddr == i_addr)) begin
      o_data = i_wrData;
    end
`endif
    if (i_addr == ZERO_REG) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/register_unit.sv
// 32 x XLEN integer register file: two combinational read ports, one synchronous write port.
// Define RU_WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_unit
  import ru_pkg::*;
#(
  parameter int              XLEN    = ru_pkg::XLEN,
  parameter int              NREGS   = ru_pkg::NREGS,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  reg_idx_t        r1,
  input  reg_idx_t        r2,
  input  reg_idx_t        rd,
  input  logic [XLEN-1:0] datawrite,
  input  logic            Ruwr,
  output logic [XLEN-1:0] r1out,
  output logic [XLEN-1:0] r2out
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [XLEN-1:0] w_r1Data;
  logic [XLEN-1:0] w_r2Data;

  // Reset wins over a concurrent write; x0 is never written so it stays at its reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == int'(SP_REG)) ? SP_INIT : '0;
      end
    end else if (Ruwr && (rd != ZERO_REG)) begin
      r_regs[rd] <= datawrite;
    end
  end

  ru_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_readPort1 (
    .i_regs   (r_regs),
    .i_addr   (r1),
`ifdef RU_WRITE_BYPASS_EN
    .i_rst    (rst),
    .i_wrEn   (Ruwr),
    .i_wrAddr (rd),
    .i_wrData (datawrite),
`endif
    .o_data   (w_r1Data)
  );

  ru_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_readPort2 (
    .i_regs   (r_regs),
    .i_addr   (r2),
`ifdef RU_WRITE_BYPASS_EN
    .i_rst    (rst),
    .i_wrEn   (Ruwr),
    .i_wrAddr (rd),
    .i_wrData (datawrite),
`endif
    .o_data   (w_r2Data)
  );

  assign r1out = w_r1Data;
  assign r2out = w_r2Data;

endmodule

// File: tb/tb_register_unit.sv
// Scoreboard testbench for register_unit: stimulus pushes expected reads, a negedge monitor checks them.
// Expectations follow RU_WRITE_BYPASS_EN so the same bench covers both builds.
module tb_register_unit;

  localparam logic [31:0] SP_INIT_TB = 32'h0001_FFF0;

  logic        clk;
  logic        rst;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [4:0]  rd;
  logic [31:0] datawrite;
  logic        Ruwr;
  logic [31:0] r1out;
  logic [31:0] r2out;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       tag;
  } exp_t;

  exp_t        expQ [$];
  exp_t        monE;
  logic [31:0] model [32];
  bit          modelKnown = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] x0Vals [4] = '{32'd481184, 32'd572264, 32'd342916, 32'd1234673};

  register_unit #(
    .XLEN    (32),
    .NREGS   (32),
    .SP_INIT (SP_INIT_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r1        (r1),
    .r2        (r2),
    .rd        (rd),
    .datawrite (datawrite),
    .Ruwr      (Ruwr),
    .r1out     (r1out),
    .r2out     (r2out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, req);
    end
  endtask

  // Architectural read rule: x0 reads zero, optionally an in-flight write is forwarded.
  function automatic logic [31:0] refRead(input logic [4:0] a, input bit iRst, input bit we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    bit bypass;
    bypass = 1'b0;
`ifdef RU_WRITE_BYPASS_EN
    bypass = 1'b1;
`endif
    if (a == 5'd0) return 32'd0;
    if (bypass && !iRst && we && wa != 5'd0 && wa == a) return wd;
    return model[a];
  endfunction

  task automatic applyStimulus(input bit iRst, input bit we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2, input string tag);
    exp_t e;
    rst       = iRst;
    Ruwr      = we;
    rd        = wa;
    datawrite = wd;
    r1        = a1;
    r2        = a2;
    if (modelKnown) begin
      e.e1  = refRead(a1, iRst, we, wa, wd);
      e.e2  = refRead(a2, iRst, we, wa, wd);
      e.tag = tag;
      expQ.push_back(e);
    end
    if (iRst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[2]   = SP_INIT_TB;
      modelKnown = 1'b1;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput({monE.tag, ".r1out"}, r1out, monE.e1);
      checkOutput({monE.tag, ".r2out"}, r2out, monE.e2);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rst = 1'b1; Ruwr = 1'b0; rd = '0; datawrite = '0; r1 = '0; r2 = '0;
    @(posedge clk);
    #1;
    $display("[TB] reset and sweep");
    applyStimulus(1, 1, 5'd4, 32'h1234, 5'd2, 5'd1, "rst_init");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd2, 5'd1, "reset_vals");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 5'd0, 32'd0, 5'(i), 5'(31 - i), "sweep");
    end

    $display("[TB] x0 immutability");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 5'd0, x0Vals[i], 5'd0, 5'd0, "x0_wr");
      applyStimulus(0, 0, 5'd0, 32'd0, 5'd1, 5'd0, "x0_rd");
    end

    $display("[TB] basic write and read");
    applyStimulus(0, 1, 5'd1, 32'd481184, 5'd1, 5'd5, "wr_x1");
    applyStimulus(0, 1, 5'd5, 32'd572264, 5'd1, 5'd5, "wr_x5");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd1, 5'd5, "rd_1_5");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd5, 5'd5, "rd_5_5");

    $display("[TB] write enable gating");
    applyStimulus(0, 0, 5'd7, 32'd1234673, 5'd7, 5'd7, "we_off");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd7, 5'd0, "rd_x7_off");
    applyStimulus(0, 1, 5'd7, 32'd1234673, 5'd0, 5'd7, "we_on");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd7, 5'd7, "rd_x7_on");

    $display("[TB] same-cycle read and write");
    applyStimulus(0, 1, 5'd3, 32'd342916, 5'd0, 5'd0, "wr_x3");
    applyStimulus(0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, "rw_same");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd3, 5'd3, "rd_x3_after");

    $display("[TB] reset priority");
    applyStimulus(0, 1, 5'd4, 32'h5555_AAAA, 5'd0, 5'd0, "wr_x4");
    applyStimulus(1, 1, 5'd4, 32'h1234, 5'd4, 5'd2, "rst_prio");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd4, 5'd2, "rd_after_rst");
    applyStimulus(0, 0, 5'd0, 32'd0, 5'd1, 5'd5, "lost_contents");

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      wa = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      applyStimulus($urandom_range(0, 29) == 0, 1'($urandom), wa, $urandom, a1, a2, "random");
    end

    checkOutput("drain", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
